// File: rtl/add256_arb.sv
// Two-requester 256-bit adder front end: one shared adder, a single-entry result
// register with valid/ready handshakes, and round-robin or fixed-priority arbitration.

module adder_256bit (
    input  logic [255:0] a,
    input  logic [255:0] b,
    input  logic         cin,
    output logic [255:0] sum,
    output logic         cout
);

    logic [256:0] full_s;

    assign full_s = {1'b0, a} + {1'b0, b} + {256'd0, cin};
    assign sum    = full_s[255:0];
    assign cout   = full_s[256];

endmodule

module add256_arb #(
    parameter logic FIXED_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [255:0] req0_a,
    input  logic [255:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [255:0] req1_a,
    input  logic [255:0] req1_b,
    input  logic         req1_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [255:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_id,
    output logic [15:0]  ops_cnt
);

    logic         can_accept_s;
    logic         grant0_s;
    logic         grant1_s;
    logic         xfer_s;
    logic [255:0] op_a_s;
    logic [255:0] op_b_s;
    logic         op_cin_s;
    logic [255:0] add_sum_s;
    logic         add_cout_s;

    logic         rsp_valid_q, rsp_valid_d;
    logic [255:0] rsp_sum_q,   rsp_sum_d;
    logic         rsp_cout_q,  rsp_cout_d;
    logic         rsp_id_q,    rsp_id_d;
    logic [15:0]  ops_cnt_q,   ops_cnt_d;
    logic         prio_q,      prio_d;

    // Grant selection: a lone valid requester always wins; ties go to prio (or req0 when fixed).
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIO || !prio_q) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (req0_valid) begin
            grant0_s = 1'b1;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // rst_n gating keeps both readies low while reset is held, even though the result slot is empty.
    assign can_accept_s = rst_n & (~rsp_valid_q | rsp_ready);
    assign req0_ready   = grant0_s & can_accept_s;
    assign req1_ready   = grant1_s & can_accept_s;
    assign xfer_s       = req0_ready | req1_ready;

    // Operand mux feeding the single shared adder.
    always_comb begin
        op_a_s   = req0_a;
        op_b_s   = req0_b;
        op_cin_s = req0_cin;
        if (grant1_s) begin
            op_a_s   = req1_a;
            op_b_s   = req1_b;
            op_cin_s = req1_cin;
        end else begin
            op_a_s   = req0_a;
            op_b_s   = req0_b;
            op_cin_s = req0_cin;
        end
    end

    adder_256bit u_adder (
        .a    (op_a_s),
        .b    (op_b_s),
        .cin  (op_cin_s),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Next-state: load on transfer, otherwise drain or hold; prio moves only on a transfer.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        ops_cnt_d   = ops_cnt_q;
        prio_d      = prio_q;
        if (xfer_s) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_sum_s;
            rsp_cout_d  = add_cout_s;
            rsp_id_d    = grant1_s;
            ops_cnt_d   = ops_cnt_q + 16'd1;
            prio_d      = FIXED_PRIO ? 1'b0 : grant0_s;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= 256'd0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
            ops_cnt_q   <= 16'd0;
            prio_q      <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
            ops_cnt_q   <= ops_cnt_d;
            prio_q      <= prio_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign ops_cnt   = ops_cnt_q;

endmodule

// File: tb/tb_add256_arb.sv
// Scoreboard bench for add256_arb: a round-robin and a fixed-priority instance run side by side
// against a transaction-level model of arbitration, result slot and counter.

module tb_add256_arb;

    localparam int NRAND = 3000;

    typedef struct packed {
        logic [255:0] s;
        logic         c;
        logic         id;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         v_s   [2][2];
    logic [255:0] a_s   [2][2];
    logic [255:0] b_s   [2][2];
    logic         c_s   [2][2];
    logic         rdy_s [2][2];
    logic         acc_s [2][2];
    logic         rsp_ready_s [2];
    logic         rsp_valid_s [2];
    logic [255:0] sum_s       [2];
    logic         cout_s      [2];
    logic         id_s        [2];
    logic [15:0]  ops_s       [2];

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sbq0[$];
    exp_t sbq1[$];

    always #5 clk = ~clk;

    add256_arb #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v_s[0][0]), .req0_ready(rdy_s[0][0]), .req0_a(a_s[0][0]), .req0_b(b_s[0][0]), .req0_cin(c_s[0][0]),
        .req1_valid(v_s[0][1]), .req1_ready(rdy_s[0][1]), .req1_a(a_s[0][1]), .req1_b(b_s[0][1]), .req1_cin(c_s[0][1]),
        .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]), .rsp_sum(sum_s[0]), .rsp_cout(cout_s[0]),
        .rsp_id(id_s[0]), .ops_cnt(ops_s[0])
    );

    add256_arb #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v_s[1][0]), .req0_ready(rdy_s[1][0]), .req0_a(a_s[1][0]), .req0_b(b_s[1][0]), .req0_cin(c_s[1][0]),
        .req1_valid(v_s[1][1]), .req1_ready(rdy_s[1][1]), .req1_a(a_s[1][1]), .req1_b(b_s[1][1]), .req1_cin(c_s[1][1]),
        .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]), .rsp_sum(sum_s[1]), .rsp_cout(cout_s[1]),
        .rsp_id(id_s[1]), .ops_cnt(ops_s[1])
    );

    task automatic check(input int d, input string name, input logic [256:0] act, input logic [256:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d @%0t: got %h, expected %h", name, d, $time, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        r = 256'd0;
        case ($urandom % 5)
            0: r = 256'd0;
            1: r = ~256'd0;
            2: r = 256'd1;
            default: for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        endcase
        return r;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? sbq0.size() : sbq1.size();
    endfunction

    // Reference model: arbitration rules, result slot occupancy and transfer count.
    initial begin : model
        logic        m_prio [2];
        logic        m_pend [2];
        logic [15:0] m_cnt  [2];
        logic [256:0] full;
        exp_t e;
        int  w;
        bit  has, can;
        for (int d = 0; d < 2; d++) begin
            m_prio[d] = 1'b0; m_pend[d] = 1'b0; m_cnt[d] = 16'd0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    m_prio[d] = 1'b0; m_pend[d] = 1'b0; m_cnt[d] = 16'd0;
                    if (d == 0) sbq0.delete(); else sbq1.delete();
                end else begin
                    check(d, "rsp_valid", rsp_valid_s[d], m_pend[d]);
                    check(d, "ops_cnt", ops_s[d], m_cnt[d]);
                    has = 1'b1;
                    w   = 0;
                    if (v_s[d][0] && v_s[d][1]) w = (d == 1 || !m_prio[d]) ? 0 : 1;
                    else if (v_s[d][0]) w = 0;
                    else if (v_s[d][1]) w = 1;
                    else has = 1'b0;
                    can = !m_pend[d] || rsp_ready_s[d];
                    check(d, "req0_ready", rdy_s[d][0], can && has && w == 0);
                    check(d, "req1_ready", rdy_s[d][1], can && has && w == 1);
                    if (can && has) begin
                        full = {1'b0, a_s[d][w]} + {1'b0, b_s[d][w]} + {256'd0, c_s[d][w]};
                        e.s  = full[255:0];
                        e.c  = full[256];
                        e.id = (w == 1);
                        if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
                        m_cnt[d] = m_cnt[d] + 16'd1;
                        if (d == 0) m_prio[d] = (w == 0);
                        m_pend[d] = 1'b1;
                    end else if (rsp_ready_s[d]) begin
                        m_pend[d] = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: each newly presented result is popped and compared; a held result must not move.
    initial begin : monitor
        logic prev_v  [2];
        logic prev_dr [2];
        exp_t held [2];
        for (int d = 0; d < 2; d++) begin
            prev_v[d] = 1'b0; prev_dr[d] = 1'b0; held[d] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    prev_v[d] = 1'b0; prev_dr[d] = 1'b0;
                end else begin
                    if (rsp_valid_s[d]) begin
                        if (!prev_v[d] || prev_dr[d]) begin
                            if (qsize(d) == 0) begin
                                vectors++;
                                miscompares++;
                                $display("FAIL unexpected_result dut%0d @%0t: got new result, expected none queued", d, $time);
                            end else begin
                                held[d] = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
                            end
                        end
                        check(d, "rsp_sum", sum_s[d], held[d].s);
                        check(d, "rsp_cout", cout_s[d], held[d].c);
                        check(d, "rsp_id", id_s[d], held[d].id);
                    end
                    prev_v[d]  = rsp_valid_s[d];
                    prev_dr[d] = rsp_valid_s[d] && rsp_ready_s[d];
                end
            end
        end
    end

    // One clock: note acceptances, step past the edge, retire accepted requests.
    task automatic cyc();
        @(negedge clk);
        for (int d = 0; d < 2; d++) for (int r = 0; r < 2; r++) acc_s[d][r] = rdy_s[d][r];
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) for (int r = 0; r < 2; r++) if (acc_s[d][r]) v_s[d][r] = 1'b0;
    endtask

    task automatic put(input int r, input logic [255:0] a, input logic [255:0] b, input logic c);
        for (int d = 0; d < 2; d++) begin
            if (!v_s[d][r]) begin
                v_s[d][r] = 1'b1; a_s[d][r] = a; b_s[d][r] = b; c_s[d][r] = c;
            end
        end
    endtask

    task automatic set_rsp_ready(input logic val);
        for (int d = 0; d < 2; d++) rsp_ready_s[d] = val;
    endtask

    task automatic idle(input int n);
        set_rsp_ready(1'b1);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin : stim
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rsp_ready_s[d] = 1'b1;
            for (int r = 0; r < 2; r++) begin
                v_s[d][r] = 1'b1; a_s[d][r] = 256'd0; b_s[d][r] = 256'd0; c_s[d][r] = 1'b0; acc_s[d][r] = 1'b0;
            end
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            check(d, "rst_req0_ready", rdy_s[d][0], 1'b0);
            check(d, "rst_req1_ready", rdy_s[d][1], 1'b0);
            check(d, "rst_rsp_valid", rsp_valid_s[d], 1'b0);
            check(d, "rst_rsp_sum", sum_s[d], 256'd0);
            check(d, "rst_ops_cnt", ops_s[d], 16'd0);
            for (int r = 0; r < 2; r++) v_s[d][r] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Overflow add: all-ones + 1
        put(0, ~256'd0, 256'd1, 1'b0);
        cyc();
        idle(3);

        // Both requesters continuously valid for four cycles
        for (int i = 0; i < 4; i++) begin
            put(0, rnd256(), rnd256(), 1'($urandom));
            put(1, rnd256(), rnd256(), 1'($urandom));
            cyc();
        end
        idle(6);

        // Backpressure with req1 waiting behind a pending result
        set_rsp_ready(1'b0);
        put(0, rnd256(), rnd256(), 1'b1);
        cyc();
        put(1, rnd256(), rnd256(), 1'b0);
        for (int i = 0; i < 3; i++) cyc();
        set_rsp_ready(1'b1);
        cyc();
        idle(4);

        // Carry-in only, then an all-zero add
        put(0, 256'd0, 256'd0, 1'b1);
        cyc();
        put(0, 256'd0, 256'd0, 1'b0);
        cyc();
        idle(3);

        // Both valid three cycles (fixed-priority instance must serve req0 each time)
        for (int i = 0; i < 3; i++) begin
            put(0, rnd256(), rnd256(), 1'($urandom));
            put(1, rnd256(), rnd256(), 1'($urandom));
            cyc();
        end
        idle(6);

        // Random traffic with random backpressure
        for (int i = 0; i < NRAND; i++) begin
            for (int d = 0; d < 2; d++) begin
                rsp_ready_s[d] = ($urandom % 4) != 0;
                for (int r = 0; r < 2; r++) begin
                    if (!v_s[d][r] && ($urandom % 4) != 0) begin
                        v_s[d][r] = 1'b1; a_s[d][r] = rnd256(); b_s[d][r] = rnd256(); c_s[d][r] = 1'($urandom);
                    end
                end
            end
            cyc();
        end
        idle(6);

        // Reset while a result is pending
        set_rsp_ready(1'b0);
        put(0, rnd256(), rnd256(), 1'b1);
        cyc();
        #2;
        for (int d = 0; d < 2; d++) for (int r = 0; r < 2; r++) v_s[d][r] = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check(d, "midrst_rsp_valid", rsp_valid_s[d], 1'b0);
            check(d, "midrst_ops_cnt", ops_s[d], 16'd0);
            check(d, "midrst_rsp_sum", sum_s[d], 256'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_rsp_ready(1'b1);
        put(0, rnd256(), rnd256(), 1'b0);
        put(1, rnd256(), rnd256(), 1'b1);
        cyc();
        idle(6);

        for (int d = 0; d < 2; d++) check(d, "scoreboard_empty", qsize(d), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
